bf16_fp8_pack_ctrl: RTL and testbench

//  Streaming sequencer around the bf16_to_fp8 converter: accepts bf16 elements on a valid/ready input stream,

---
 rtl/bf16_fp8_pack_ctrl_pkg.sv | 15 +
 rtl/bf16_fp8_pack_ctrl_bf16_to_fp8.sv | 20 ++
 rtl/bf16_fp8_pack_ctrl.sv | 111 +++++++++++
 tb/tb_bf16_fp8_pack_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_fp8_pack_ctrl_pkg.sv
// Shared widths, exponent biases and FSM encoding for the bf16 -> fp8 packing path.
package bf16_fp8_pack_ctrl_pkg;

    localparam int BF16_W        = 16;
    localparam int FP8_W         = 8;
    localparam int FP8_EXP_BIAS  = 7;
    localparam int BF16_EXP_BIAS = 127;
    localparam int EXP_REBIAS    = BF16_EXP_BIAS - FP8_EXP_BIAS;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_t;

endpackage

// File: rtl/bf16_fp8_pack_ctrl_bf16_to_fp8.sv
// Existing bf16 -> fp8 (E4M3 layout) converter: mantissa truncation and exponent rebias
// modulo 16, with no rounding or saturation.
module bf16_to_fp8
    import bf16_fp8_pack_ctrl_pkg::*;
(
    input  logic [BF16_W-1:0] i_bf16,
    output logic [FP8_W-1:0]  o_fp8
);

    logic [7:0] w_exp;
    logic [3:0] w_unusedExpHi;

    // Only the low four exponent bits survive, so out-of-range exponents wrap silently.
    always_comb begin
        w_exp         = i_bf16[14:7] - 8'(EXP_REBIAS);
        w_unusedExpHi = w_exp[7:4];
        o_fp8         = {i_bf16[15], w_exp[3:0], i_bf16[6:4]};
    end

endmodule

// File: rtl/bf16_fp8_pack_ctrl.sv
// Streams bf16 elements through one shared converter and packs LANES fp8 bytes per output
// word, with in_last closing a partial word early.
module bf16_fp8_pack_ctrl
    import bf16_fp8_pack_ctrl_pkg::*;
#(
    parameter int LANES = 4,
    parameter int OUT_W = 8 * LANES,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BF16_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [LANES-1:0]  out_mask,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int IDX_W = $clog2(LANES);

    pack_state_t      r_state;
    pack_state_t      w_nextState;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_nextIdx;
    logic [OUT_W-1:0] r_data;
    logic [OUT_W-1:0] w_nextData;
    logic [LANES-1:0] r_mask;
    logic [LANES-1:0] w_nextMask;
    logic             r_last;
    logic             w_nextLast;
    logic [CNT_W-1:0] r_wordCnt;
    logic [FP8_W-1:0] w_byte;
    logic [LANES-1:0] w_laneWe;
    logic             w_accept;
    logic             w_handoff;
    logic             w_complete;

    bf16_to_fp8 u_cvt (
        .i_bf16 (in_data),
        .o_fp8  (w_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FILL;
            r_idx     <= '0;
            r_data    <= '0;
            r_mask    <= '0;
            r_last    <= 1'b0;
            r_wordCnt <= '0;
        end else begin
            r_state <= w_nextState;
            r_idx   <= w_nextIdx;
            r_data  <= w_nextData;
            r_mask  <= w_nextMask;
            r_last  <= w_nextLast;
            if (w_handoff) begin
                r_wordCnt <= r_wordCnt + CNT_W'(1);
            end
        end
    end

    // A word completing on the same beat as a handoff keeps the FSM in HOLD with no bubble.
    always_comb begin
        w_accept    = in_valid & in_ready;
        w_handoff   = out_valid & out_ready;
        w_complete  = w_accept & ((r_idx == IDX_W'(LANES - 1)) | in_last);
        w_nextState = r_state;
        if (w_complete) begin
            w_nextState = ST_HOLD;
        end else if (w_handoff) begin
            w_nextState = ST_FILL;
        end
    end

    // In HOLD the index is always 0, so a pass-through beat naturally lands in lane 0.
    always_comb begin
        w_nextData = w_handoff ? '0 : r_data;
        w_nextMask = w_handoff ? '0 : r_mask;
        w_nextLast = w_handoff ? 1'b0 : r_last;
        w_nextIdx  = r_idx;
        for (int k = 0; k < LANES; k++) begin
            w_laneWe[k] = w_accept & (r_idx == IDX_W'(k));
            if (w_laneWe[k]) begin
                w_nextData[k*FP8_W +: FP8_W] = w_byte;
                w_nextMask[k]                = 1'b1;
            end
        end
        if (w_accept) begin
            w_nextLast = w_nextLast | in_last;
            w_nextIdx  = w_complete ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_comb begin
        out_valid = (r_state == ST_HOLD);
        in_ready  = (r_state == ST_FILL) ? 1'b1 : out_ready;
        busy      = (r_state == ST_HOLD) | (r_idx != '0);
        out_data  = r_data;
        out_mask  = r_mask;
        out_last  = r_last;
        word_cnt  = r_wordCnt;
    end

endmodule

// File: tb/tb_bf16_fp8_pack_ctrl.sv
// Directed and randomised stream bench for bf16_fp8_pack_ctrl with a queue-based packing model.
module tb_bf16_fp8_pack_ctrl;

    localparam int LANES = 4;
    localparam int OUT_W = 8 * LANES;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [LANES-1:0] out_mask;
    logic             out_last;
    logic             busy;
    logic [CNT_W-1:0] word_cnt;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [LANES-1:0] mask;
        logic             last;
    } word_t;

    word_t            expQ[$];
    logic [OUT_W-1:0] pendData = '0;
    logic [LANES-1:0] pendMask = '0;
    int               pendCnt = 0;
    logic [CNT_W-1:0] modelCnt = '0;
    int               checks = 0;
    int               errors = 0;
    int               wordsSeen = 0;
    int               acceptsSeen = 0;
    int               cycleCnt = 0;
    logic [OUT_W-1:0] lastData = '0;
    logic [LANES-1:0] lastMask = '0;
    logic             lastLast = 1'b0;

    bf16_fp8_pack_ctrl #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_last  (out_last),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Reference conversion from the number-format rules: rebias the exponent by 120 modulo 16.
    function automatic logic [7:0] refConv(input logic [15:0] b);
        int e;
        e = int'(b[14:7]) - 120;
        e = ((e % 16) + 16) % 16;
        return {b[15], 4'(e), b[6:4]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Drives one element and waits, with a cycle bound, until it has been taken.
    task automatic applyStimulus(input logic [15:0] d, input logic l);
        int  waitCycles;
        bit  done;
        waitCycles = 0;
        done       = 1'b0;
        in_valid   = 1'b1;
        in_data    = d;
        in_last    = l;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            if (!done) begin
                waitCycles++;
                if (waitCycles > 60) begin
                    checkOutput("acceptTimeout", 64'(0), 64'(1));
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'b0;
    endtask

    // Mid-cycle compare process: checks every output against the packing model and advances it.
    initial begin
        word_t w;
        bit    expReady;
        bit    expValid;
        forever begin
            @(negedge clk);
            if (rst) begin
                expQ.delete();
                pendData = '0;
                pendMask = '0;
                pendCnt  = 0;
                modelCnt = '0;
                checkOutput("rstOutValid", 64'(out_valid), 64'(0));
                checkOutput("rstBusy", 64'(busy), 64'(0));
                checkOutput("rstWordCnt", 64'(word_cnt), 64'(0));
                checkOutput("rstOutData", 64'(out_data), 64'(0));
            end else begin
                expValid = (expQ.size() != 0);
                expReady = !expValid || out_ready;
                checkOutput("outValid", 64'(out_valid), 64'(expValid));
                checkOutput("inReady", 64'(in_ready), 64'(expReady));
                checkOutput("busy", 64'(busy), 64'(expValid || (pendCnt != 0)));
                checkOutput("wordCnt", 64'(word_cnt), 64'(modelCnt));
                if (expValid) begin
                    checkOutput("outData", 64'(out_data), 64'(expQ[0].data));
                    checkOutput("outMask", 64'(out_mask), 64'(expQ[0].mask));
                    checkOutput("outLast", 64'(out_last), 64'(expQ[0].last));
                    if (out_ready) begin
                        lastData = out_data;
                        lastMask = out_mask;
                        lastLast = out_last;
                        void'(expQ.pop_front());
                        modelCnt = modelCnt + 1'b1;
                        wordsSeen++;
                    end
                end
                if (in_valid && expReady) begin
                    pendData[pendCnt*8 +: 8] = refConv(in_data);
                    pendMask[pendCnt]        = 1'b1;
                    pendCnt++;
                    acceptsSeen++;
                    if (pendCnt == LANES || in_last) begin
                        w.data = pendData;
                        w.mask = pendMask;
                        w.last = in_last;
                        expQ.push_back(w);
                        pendData = '0;
                        pendMask = '0;
                        pendCnt  = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  t0;
        int  w0;
        int  a0;
        bit  randOn;
        logic [15:0] burst[8];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("resetOutValid", 64'(out_valid), 64'(0));
        checkOutput("resetInReady", 64'(in_ready), 64'(1));
        checkOutput("resetWordCnt", 64'(word_cnt), 64'(0));

        // Test 1: one full word, back-to-back.
        applyStimulus(16'h3F80, 1'b0);
        applyStimulus(16'h3FC0, 1'b0);
        applyStimulus(16'hC000, 1'b0);
        applyStimulus(16'h3F00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t1Data", 64'(lastData), 64'h30C03C38);
        checkOutput("t1Mask", 64'(lastMask), 64'hF);
        checkOutput("t1Last", 64'(lastLast), 64'(0));
        checkOutput("t1WordCnt", 64'(word_cnt), 64'(1));

        // Test 2: partial word closed by in_last.
        applyStimulus(16'h3F80, 1'b0);
        applyStimulus(16'hC000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t2Data", 64'(lastData), 64'h0000C038);
        checkOutput("t2Mask", 64'(lastMask), 64'h3);
        checkOutput("t2Last", 64'(lastLast), 64'(1));

        // Test 3: back-pressure with 8 elements offered.
        for (int i = 0; i < 8; i++) burst[i] = 16'h3F80 + 16'(i * 16'h0090);
        out_ready = 1'b0;
        a0 = acceptsSeen;
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(burst[i], 1'b0);
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                checkOutput("t3Accepts", 64'(acceptsSeen - a0), 64'(4));
                checkOutput("t3InReady", 64'(in_ready), 64'(0));
                checkOutput("t3OutValid", 64'(out_valid), 64'(1));
                out_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t3WordCnt", 64'(word_cnt), 64'(4));

        // Test 4a: 400 elements at full rate.
        t0 = cycleCnt;
        w0 = wordsSeen;
        for (int i = 0; i < 400; i++) applyStimulus(16'($urandom), 1'b0);
        checkOutput("t4Cycles", 64'(cycleCnt - t0), 64'(400));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t4Words", 64'(wordsSeen - w0), 64'(100));

        // Test 4b: random gaps, random back-pressure, occasional in_last.
        randOn = 1'b1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    applyStimulus(16'($urandom), (i == 199) || ($urandom_range(0, 9) == 0));
                end
                randOn = 1'b0;
            end
            begin
                while (randOn) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("t4Drained", 64'(expQ.size()), 64'(0));

        // Test 5: asynchronous reset mid-word.
        applyStimulus(16'h3F80, 1'b0);
        applyStimulus(16'h3FC0, 1'b0);
        checkOutput("t5PreBusy", 64'(busy), 64'(1));
        checkOutput("t5PreMask", 64'(out_mask), 64'h3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5Busy", 64'(busy), 64'(0));
        checkOutput("t5Data", 64'(out_data), 64'(0));
        checkOutput("t5Mask", 64'(out_mask), 64'(0));
        checkOutput("t5WordCnt", 64'(word_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(16'h3F80, 1'b0);
        applyStimulus(16'h3FC0, 1'b0);
        applyStimulus(16'hC000, 1'b0);
        applyStimulus(16'h3F00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t5CleanMask", 64'(lastMask), 64'hF);
        checkOutput("t5CleanData", 64'(lastData), 64'h30C03C38);

        // Test 6: word counter wrap.
        force dut.r_wordCnt = 16'hFFFF;
        modelCnt = 16'hFFFF;
        #1;
        release dut.r_wordCnt;
        checkOutput("t6Preload", 64'(word_cnt), 64'hFFFF);
        applyStimulus(16'h4000, 1'b0);
        applyStimulus(16'h4040, 1'b0);
        applyStimulus(16'hBF80, 1'b0);
        applyStimulus(16'h3E80, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6Wrap", 64'(word_cnt), 64'(0));
        checkOutput("t6Idle", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
